mod_residue_bcd_serializer: RTL and testbench

MOD_RESIDUE_BCD_SERIALIZER -- requirements
Module: mod_residue_bcd_serializer

---
 rtl/residue_pkg.sv | 14 +
 rtl/mod_residue_bcd_serializer_if.sv | 25 ++
 rtl/bcd_dabble_step.sv | 23 ++
 rtl/mod_residue_bcd_serializer.sv | 143 ++++++++++++++
 tb/tb_mod_residue_bcd_serializer.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/residue_pkg.sv
// Shared defaults and FSM state type for the residue-to-BCD serializer.
package residue_pkg;

    localparam int MODULUS_DEF = 1234101;
    localparam int NDIG_DEF    = 7;
    localparam int NBITS_DEF   = 21;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        EMIT    = 2'd2
    } state_e;

endpackage

// File: rtl/mod_residue_bcd_serializer_if.sv
// Residue input and BCD digit output streams of the serializer.
// Both streams use valid/ready: a beat moves on a rising edge where valid && ready;
// the producer holds data stable while valid is high and ready is low.
interface mod_residue_bcd_serializer_if;

    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  out_digit;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        err;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_digit, out_valid, out_last, err
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_digit, out_valid, out_last, err
    );

endinterface

// File: rtl/bcd_dabble_step.sv
// One double-dabble step: add 3 to every BCD nibble >= 5, then shift in one binary bit.
module bcd_dabble_step #(
    parameter int NDIG = 7
) (
    input  logic [4*NDIG-1:0] bcd_i,
    input  logic              bit_i,
    output logic [4*NDIG-1:0] bcd_o
);

    logic [4*NDIG-1:0] adj;
    logic              carry_unused;

    always_comb begin
        adj = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (bcd_i[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_i[4*i +: 4] + 4'd3;
            else                         adj[4*i +: 4] = bcd_i[4*i +: 4];
        end
        // The top bit falls off; it is always zero for in-range residues.
        {carry_unused, bcd_o} = {adj, bit_i};
    end

endmodule

// File: rtl/mod_residue_bcd_serializer.sv
// Converts a residue to NDIG BCD digits and streams them MSD first.
// Optional macro RESIDUE_BCD_LZS_EN skips leading zero digits.
module mod_residue_bcd_serializer
    import residue_pkg::*;
#(
    parameter int MODULUS = MODULUS_DEF,
    parameter int NDIG    = NDIG_DEF,
    parameter int NBITS   = NBITS_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    mod_residue_bcd_serializer_if.slave   bus,
    output state_e                        dbg_state
);

    localparam int              BW       = 4 * NDIG;
    localparam int              CW       = $clog2(NBITS + 1);
    localparam int              DW       = $clog2(NDIG + 1);
    localparam logic [31:0]     MOD_U    = 32'(MODULUS);
    localparam logic [CW-1:0]   LAST_BIT = CW'(NBITS - 1);
    localparam logic [DW-1:0]   LAST_DIG = DW'(NDIG - 1);

    state_e            state_q, state_d;
    logic [NBITS-1:0]  bin_q, bin_d;
    logic [BW-1:0]     bcd_q, bcd_d, bcd_step, bcd_sh;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DW-1:0]     dig_q, dig_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic              err_q, err_d;
    logic [3:0]        out_digit_q, out_digit_d;
    logic [3:0]        top_nib, next_nib;

    bcd_dabble_step #(.NDIG(NDIG)) u_step (
        .bcd_i (bcd_q),
        .bit_i (bin_q[NBITS-1]),
        .bcd_o (bcd_step)
    );

    // During EMIT the BCD register shifts left so the current digit is always on top.
    assign top_nib  = bcd_q[BW-1 -: 4];
    assign bcd_sh   = bcd_q << 4;
    assign next_nib = bcd_sh[BW-1 -: 4];

    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        bcd_d       = bcd_q;
        cnt_d       = cnt_q;
        dig_d       = dig_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_digit_d = out_digit_q;
        err_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    if (bus.in_data >= MOD_U) begin
                        err_d = 1'b1;
                    end else begin
                        bin_d   = bus.in_data[NBITS-1:0];
                        bcd_d   = '0;
                        cnt_d   = '0;
                        state_d = CONVERT;
                    end
                end
            end
            CONVERT: begin
                bcd_d = bcd_step;
                bin_d = bin_q << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    state_d = EMIT;
                    dig_d   = '0;
                end
            end
            EMIT: begin
                // out_valid low in EMIT means the next digit has not been presented yet.
                if (!out_valid_q) begin
`ifdef RESIDUE_BCD_LZS_EN
                    if (top_nib == 4'd0 && dig_q != LAST_DIG) begin
                        bcd_d = bcd_sh;
                        dig_d = dig_q + 1'b1;
                    end else
`endif
                    begin
                        out_valid_d = 1'b1;
                        out_digit_d = top_nib;
                        out_last_d  = (dig_q == LAST_DIG);
                    end
                end else if (bus.out_ready) begin
                    if (out_last_q) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        state_d     = IDLE;
                    end else begin
                        bcd_d       = bcd_sh;
                        dig_d       = dig_q + 1'b1;
                        out_digit_d = next_nib;
                        out_last_d  = ((dig_q + 1'b1) == LAST_DIG);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bin_q       <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            dig_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_digit_q <= 4'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            bcd_q       <= bcd_d;
            cnt_q       <= cnt_d;
            dig_q       <= dig_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_digit_q <= out_digit_d;
            err_q       <= err_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_digit = out_digit_q;
    assign bus.err       = err_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_mod_residue_bcd_serializer.sv
// Directed bench for mod_residue_bcd_serializer; expected digits go into a queue
// that a negedge monitor drains on every output transfer.
module tb_mod_residue_bcd_serializer;
    import residue_pkg::*;

    logic   clk;
    logic   rst_n;
    state_e dbg_state;
    mod_residue_bcd_serializer_if bus();

    mod_residue_bcd_serializer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // scoreboard
    logic [4:0] exp_q[$];
    int         n_checks = 0;
    int         n_err    = 0;
    int         err_cnt  = 0;
    int         valid_cnt = 0;
    int         last_xfer_cyc = -1;
    logic       held_v = 1'b0;
    logic [4:0] held;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input int d[7]);
`ifdef RESIDUE_BCD_LZS_EN
        bit lead = 1'b1;
`endif
        for (int i = 0; i < 7; i++) begin
`ifdef RESIDUE_BCD_LZS_EN
            if (lead && d[i] == 0 && i != 6) continue;
            lead = 1'b0;
`endif
            exp_q.push_back({(i == 6), 4'(d[i])});
        end
    endtask

    // monitor
    always @(negedge clk) begin
        if (!rst_n) begin
            held_v = 1'b0;
        end else begin
            if (bus.err) err_cnt++;
            if (bus.out_valid) valid_cnt++;
            if (held_v && bus.out_valid) begin
                n_checks++;
                if ({bus.out_last, bus.out_digit} !== held) begin
                    n_err++;
                    $display("FAIL stall_hold: got %0h expected %0h", {bus.out_last, bus.out_digit}, held);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_digit: got last=%0d digit=%0d expected none",
                             bus.out_last, bus.out_digit);
                end else begin
                    logic [4:0] e;
                    e = exp_q.pop_front();
                    if ({bus.out_last, bus.out_digit} !== e) begin
                        n_err++;
                        $display("FAIL digit: got last=%0d digit=%0d expected last=%0d digit=%0d",
                                 bus.out_last, bus.out_digit, e[4], e[3:0]);
                    end
                end
                if (bus.out_last) last_xfer_cyc = cyc + 1;
                held_v = 1'b0;
            end else if (bus.out_valid) begin
                held_v = 1'b1;
                held   = {bus.out_last, bus.out_digit};
            end else begin
                held_v = 1'b0;
            end
        end
    end

    // out_ready driver: always ready, or the 1,0,0,1 stall pattern
    bit stall_en = 1'b0;
    int pat[4] = '{1, 0, 0, 1};
    int pidx = 0;
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_en) begin
                bus.out_ready = pat[pidx][0];
                pidx = (pidx + 1) % 4;
            end else begin
                bus.out_ready = 1'b1;
            end
        end
    end

    // driver tasks
    task automatic send(input logic [31:0] v, output int acc_cyc);
        int g = 0;
        bus.in_data  = v;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && g < 200) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (g >= 200) chk("send_timeout", 32'(g), 32'd0);
        @(posedge clk);
        #1;
        acc_cyc      = cyc;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int c);
        int g = 0;
        while (!bus.out_valid && g < 100) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (g >= 100) chk("valid_timeout", 32'(g), 32'd0);
        c = cyc;
    endtask

    task automatic wait_drain(input string name);
        int g = 0;
        while ((exp_q.size() != 0 || !bus.in_ready) && g < 300) begin
            @(posedge clk);
            #1;
            g++;
        end
        chk(name, 32'(exp_q.size()), 32'd0);
        chk({name, "_idle"}, 32'(bus.in_ready), 32'd1);
    endtask

    // stimulus
    initial begin
        int acc, vc, e0, v0, acc6;
        rst_n        = 1'b0;
        bus.in_data  = '0;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_last",  32'(bus.out_last),  32'd0);
        chk("rst_out_digit", 32'(bus.out_digit), 32'd0);
        chk("rst_err",       32'(bus.err),       32'd0);
        chk("rst_state",     32'(dbg_state),     32'(IDLE));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // 1234100 with continuous ready, check latency
        push_exp('{1, 2, 3, 4, 1, 0, 0});
        send(32'd1234100, acc);
        chk("accept_state", 32'(dbg_state), 32'(CONVERT));
        chk("accept_in_ready", 32'(bus.in_ready), 32'd0);
        wait_valid(vc);
        chk("latency", 32'(vc - acc), 32'd22);
        wait_drain("drain_1234100");

        // zero
        push_exp('{0, 0, 0, 0, 0, 0, 0});
        send(32'd0, acc);
        wait_drain("drain_0");

        // out-of-range inputs
        e0 = err_cnt;
        v0 = valid_cnt;
        send(32'd1234101, acc);
        chk("err_pulse_a", 32'(bus.err), 32'd1);
        chk("err_in_ready_a", 32'(bus.in_ready), 32'd1);
        chk("err_state_a", 32'(dbg_state), 32'(IDLE));
        @(posedge clk);
        #1;
        chk("err_clear_a", 32'(bus.err), 32'd0);
        send(32'hFFFF_FFFF, acc);
        chk("err_pulse_b", 32'(bus.err), 32'd1);
        chk("err_in_ready_b", 32'(bus.in_ready), 32'd1);
        repeat (25) @(posedge clk);
        #1;
        chk("err_count", 32'(err_cnt - e0), 32'd2);
        chk("err_no_valid", 32'(valid_cnt - v0), 32'd0);
        chk("err_in_ready_end", 32'(bus.in_ready), 32'd1);

        // 42 with stalls
        push_exp('{0, 0, 0, 0, 0, 4, 2});
        pidx     = 0;
        stall_en = 1'b1;
        send(32'd42, acc);
        wait_drain("drain_42");
        stall_en = 1'b0;
        @(posedge clk);
        #1;

        // reset during CONVERT
        send(32'd999999, acc);
        repeat (10) @(posedge clk);
        #1;
        chk("mid_state", 32'(dbg_state), 32'(CONVERT));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_state", 32'(dbg_state), 32'(IDLE));
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        v0 = valid_cnt;
        @(posedge clk);
        #1;
        chk("mid_rel_in_ready", 32'(bus.in_ready), 32'd1);
        repeat (30) @(posedge clk);
        #1;
        chk("mid_no_valid", 32'(valid_cnt - v0), 32'd0);
        push_exp('{0, 0, 0, 0, 0, 0, 7});
        send(32'd7, acc);
        wait_drain("drain_7");

        // back-to-back 5 then 6 with in_valid held
        push_exp('{0, 0, 0, 0, 0, 0, 5});
        push_exp('{0, 0, 0, 0, 0, 0, 6});
        send(32'd5, acc);
        send(32'd6, acc6);
        chk("b2b_accept", 32'(acc6), 32'(last_xfer_cyc + 1));
        wait_drain("drain_b2b");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
